// File: rtl/pulse_window_if.sv
// Result stream from the window counter to the stats/CSR collector.
// The counter drives the record and valid; the collector drives ready.
interface pulse_window_if #(
   parameter int CNT_W = 6
) ();
   logic             m_valid;
   logic             m_ready;
   logic [CNT_W-1:0] m_count;
   logic             m_sat;

   modport master (output m_valid, m_count, m_sat, input m_ready);
   modport slave  (input m_valid, m_count, m_sat, output m_ready);
endinterface

// File: rtl/pulse_window_counter.sv
// Counts detector pulses over back-to-back programmable windows and queues
// {sat, count} per window into a small FIFO drained by valid/ready.
module pulse_window_counter #(
   parameter int WIN_W = 8,
   parameter int CNT_W = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [WIN_W-1:0]           win_len,
   input  logic                       pulse_in,
   pulse_window_if.master             m,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf_sticky,
   input  logic                       clr_ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_n;
   logic [WIN_W-1:0] win_cnt, win_cnt_n, win_len_q, win_len_q_n;
   logic [CNT_W-1:0] ev_cnt, ev_cnt_n;
   logic             sat_q, sat_n;
   logic             push;
   logic [CNT_W:0]   push_rec;

   logic             first, last, at_max;
   logic [WIN_W-1:0] cnt_eff, len_eff;
   logic [CNT_W-1:0] ev_base, ev_new;
   logic             sat_base, sat_new;

   // Window cycle 0 is either entry from IDLE or the cycle after a window end;
   // in both cases counters restart and win_len is taken live.
   always_comb begin
      first    = (state == IDLE) || (win_cnt == '0);
      cnt_eff  = first ? '0 : win_cnt;
      len_eff  = first ? win_len : win_len_q;
      ev_base  = first ? '0 : ev_cnt;
      sat_base = first ? 1'b0 : sat_q;
      at_max   = &ev_base;
      ev_new   = ev_base + CNT_W'(pulse_in && !at_max);
      sat_new  = sat_base | (pulse_in & at_max);
      last     = (cnt_eff == len_eff);
   end

   always_comb begin
      state_n     = state;
      win_cnt_n   = win_cnt;
      win_len_q_n = win_len_q;
      ev_cnt_n    = ev_cnt;
      sat_n       = sat_q;
      push        = 1'b0;
      push_rec    = {sat_new, ev_new};
      if (!en) begin
         // Disable wins over a same-cycle window end: partial window dropped.
         state_n   = IDLE;
         win_cnt_n = '0;
         ev_cnt_n  = '0;
         sat_n     = 1'b0;
      end else begin
         state_n     = RUN;
         win_len_q_n = len_eff;
         if (last) begin
            push      = 1'b1;
            win_cnt_n = '0;
            ev_cnt_n  = '0;
            sat_n     = 1'b0;
         end else begin
            win_cnt_n = cnt_eff + WIN_W'(1);
            ev_cnt_n  = ev_new;
            sat_n     = sat_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         win_cnt   <= '0;
         win_len_q <= '0;
         ev_cnt    <= '0;
         sat_q     <= 1'b0;
      end else begin
         state     <= state_n;
         win_cnt   <= win_cnt_n;
         win_len_q <= win_len_q_n;
         ev_cnt    <= ev_cnt_n;
         sat_q     <= sat_n;
      end
   end

   logic [CNT_W:0]   mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             full, pop, push_ok, drop;

   always_comb begin
      full    = (level == LW'(DEPTH));
      pop     = m.m_valid & m.m_ready;
      push_ok = push & (!full | pop);
      drop    = push & full & !pop;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_rec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (drop)         ovf_sticky <= 1'b1;
         else if (clr_ovf) ovf_sticky <= 1'b0;
      end
   end

   always_comb begin
      m.m_valid = (level != '0);
      m.m_count = m.m_valid ? mem[rd_ptr][CNT_W-1:0] : '0;
      m.m_sat   = m.m_valid ? mem[rd_ptr][CNT_W] : 1'b0;
   end
endmodule

// File: doc/pulse_window_counter.md
Name: pulse_window_counter

Overview:
Downstream consumer of the run-detector FSM's single-bit `out` pulse stream. It counts detector pulses over consecutive programmable-length windows. Each completed window's count, plus a saturation flag, is pushed into a small FIFO. Results drain through a valid/ready interface to the stats/CSR collector.

Parameters:
WIN_W, 8, width of window-length field; max window = 2^WIN_W cycles
CNT_W, 6, width of per-window event count
DEPTH, 4, result FIFO depth; power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = windows running; 0 = idle, partial window discarded
win_len  in  WIN_W  window length minus 1; sampled in cycle 0 of each window
pulse_in  in  1  event pulse from detector; one event per high cycle
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts head when m_valid & m_ready
m_count  out  CNT_W  head record event count
m_sat  out  1  head record count saturated
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
ovf_sticky  out  1  a record was dropped due to full FIFO
clr_ovf  in  1  clears ovf_sticky

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state IDLE; win_cnt, ev_cnt, sat_q = 0.
  - FIFO empty.
  - m_valid=0, m_count=0, m_sat=0, level=0, ovf_sticky=0.
- FSM states: IDLE, RUN.
- IDLE:
  - en=0: stay.
  - en=1: this cycle is window cycle 0. Latch win_len into win_len_q. Count pulse_in. Go RUN, unless the window also ends this cycle (win_len=0), in which case push and remain window-aligned.
- RUN, each cycle with en=1:
  - If pulse_in=1, ev_cnt += 1. ev_cnt saturates at 2^CNT_W-1; sat_q is set when an increment is attempted at max.
  - win_cnt += 1.
- Last window cycle (win_cnt == win_len_q, or win_len=0 in cycle 0):
  - Push record {sat, count}, including this cycle's pulse.
  - Next cycle starts a new window cycle 0: win_cnt=0, ev_cnt=0, sat_q=0, win_len re-sampled. No dead cycle between windows.
- en=0 in RUN: go IDLE, clear counters, discard partial window (no push). en=0 takes priority over a window-end push in the same cycle.
- win_len change mid-window has no effect until the next window's cycle 0.
- FIFO:
  - Pop when m_valid & m_ready.
  - Push when FIFO not full, or full with a simultaneous pop (accepted, level unchanged).
  - Push to full FIFO without pop: record dropped, ovf_sticky set next cycle.
  - Simultaneous push and pop when empty is impossible (m_valid=0).
  - Pointers wrap modulo DEPTH; order strictly FIFO.
- Output timing:
  - m_valid = (level != 0).
  - Record pushed at a clock edge is visible on m_count/m_sat after that edge: 1-cycle latency from the window's last cycle.
  - m_count/m_sat held stable while m_valid & !m_ready.
  - When empty, m_count=0 and m_sat=0.
- ovf_sticky: set on drop. Cleared by clr_ovf when no drop occurs in the same cycle; set wins over clear.
- Reset mid-operation: immediate return to reset values. FIFO contents and partial window lost.

Test Plan:
- Basic window: win_len=3, m_ready=1, en rises, pulse_in 1,0,1,1 over window cycles 0..3 -> one record count=3, sat=0. m_valid high exactly 1 cycle after cycle 3, for 1 cycle; next window starts immediately.
- Saturation: CNT_W=6, win_len=99, pulse_in held 1 -> record count=63, sat=1. Following window with no pulses -> count=0, sat=0.
- Overflow: m_ready=0, win_len=0, pulse_in 1,0,1,0,1 -> level reaches 4, 5th record dropped, ovf_sticky=1. Drain yields counts 1,0,1,0 in order. clr_ovf -> ovf_sticky=0.
- Full with simultaneous push and pop: level=4, m_ready=1 in a window-end cycle -> push accepted, level stays 4, ovf_sticky stays 0.
- Abort: win_len=3, en dropped in window cycle 2 after 2 pulses -> no record. Re-enable with win_len=1 and one pulse -> record count=1 after 2 cycles.
- Async reset: assert rst_n low mid-window with level=3, between clock edges -> m_valid, level, m_count, ovf_sticky all 0 immediately. After release, first window counts from 0.
